pc_gen: RTL

//   Parametrised program-counter generator for the fetch stage. Successor to the single-register PC.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_ras.sv | 72 +++++++
 rtl/pc_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_RAS,
        SEL_BR,
        SEL_TRAP
    } sel_e;

    // Keeps every bit except the low `align` bits; the caller slices the result to XLEN.
    function automatic logic [63:0] align_mask(input int align);
        return ~((64'd1 << align) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a write pointer plus a count that saturates at RAS_DEPTH.
// When the stack is full, a push overwrites the oldest entry.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, top_idx, wr_idx;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en;

    // ptr_q points at the next free slot, so the top sits one entry below it.
    assign top_idx = ptr_q - PW'(1);
    assign top_o   = mem_q[top_idx];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DEPTH_C);

    // A push together with a pop replaces the top in place instead of moving the pointer.
    assign wr_en  = push_i && !clear_i;
    assign wr_idx = pop_i ? top_idx : ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i) begin
            ptr_d = ptr_q;
            cnt_d = cnt_q;
        end else if (push_i) begin
            ptr_d = ptr_q + PW'(1);
            if (cnt_q != DEPTH_C) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop_i) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && wr_en) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with IDLE/RUN control, stall hold, prioritised redirects
// (trap > branch > return prediction) and a return-address stack.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RST_VEC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int              INC       = 4,
    parameter int              ALIGN     = 2,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            trap_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);
    localparam logic [63:0]     MASK64 = align_mask(ALIGN);
    localparam logic [XLEN-1:0] MASK   = MASK64[XLEN-1:0];

    state_e          state_q, state_d;
    sel_e            sel;
    logic [XLEN-1:0] pc_q, pc_d, pc_seq, ras_top;
    logic            ras_push, ras_pop, ras_clear, ras_empty, ras_full;

    assign pc_seq = pc_q + XLEN'(INC);

    // Next-state and select decode; IDLE ignores everything except start_i.
    always_comb begin
        state_d   = state_q;
        sel       = SEL_HOLD;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (trap_i) begin
                    sel       = SEL_TRAP;
                    ras_clear = 1'b1;
                end else if (redirect_i) begin
                    sel = SEL_BR;
                end else if (stall_i) begin
                    sel = SEL_HOLD;
                end else begin
                    ras_push = call_i;
                    if (ret_i && !ras_empty) begin
                        sel     = SEL_RAS;
                        ras_pop = 1'b1;
                    end else begin
                        sel = SEL_SEQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_HOLD: pc_d = pc_q;
            SEL_SEQ:  pc_d = pc_seq;
            SEL_RAS:  pc_d = ras_top;
            SEL_BR:   pc_d = redirect_pc_i & MASK;
            SEL_TRAP: pc_d = TRAP_VEC & MASK;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            pc_q    <= RST_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .clear_i     (ras_clear),
        .push_data_i (pc_seq),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    assign pc_o        = pc_q;
    assign pc_valid_o  = (state_q == S_RUN);
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;

endmodule
